alarm_trigger: RTL and testbench

- Upstream stage of the alarm sounder; produces its `ring1` and `ring2` request pulses.
- Holds a user-settable alarm time (BCD hh:mm) and compares it with the running clock time on each 1 Hz tick.
- Fires `ring1` on an alarm match or snooze expiry, and `ring2` as a top-of-hour chime.
- Also owns the alarm-set mode FSM, the alarm enable, and snooze timing.

---
 rtl/alarm_trigger.sv | 177 +++++++++++++++++
 tb/tb_alarm_trigger.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger.sv
// Alarm trigger: stores a BCD alarm time, compares it with the running clock on
// each 1 Hz tick, and issues ring1 (alarm/snooze) and ring2 (hourly chime) pulses.
module alarm_trigger #(
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned SNOOZE_WIN = 3,
  parameter bit          CHIME_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz_posedge,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_en,
  input  logic       btn_snooze,
  output logic       ring1,
  output logic       ring2,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min,
  output logic       alarm_en,
  output logic [1:0] set_state,
  output logic       snooze_active
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StSetHour = 2'b01,
    StSetMin  = 2'b10
  } set_state_e;

  localparam logic [9:0] SnoozeLoad = 10'(SNOOZE_SEC);
  localparam logic [3:0] WinLoad    = 4'(SNOOZE_WIN);

  set_state_e state_q, state_d;
  logic       set_hist_q, inc_hist_q, en_hist_q, snz_hist_q;
  logic [7:0] hour_q, hour_d, min_q, min_d;
  logic       en_q, en_d;
  logic       active_q, active_d;
  logic [9:0] cnt_q, cnt_d;
  logic [3:0] win_q, win_d;
  logic       ring1_q, ring1_d, ring2_q, ring2_d;

  logic set_edge, inc_edge, en_edge, snz_edge;
  logic tick_idle, hit, chime, fire;

  function automatic logic [7:0] inc_hour(input logic [7:0] h);
    if (h == 8'h23)          return 8'h00;
    else if (h[3:0] == 4'd9) return {h[7:4] + 4'd1, 4'd0};
    else                     return {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m == 8'h59)          return 8'h00;
    else if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
    else                     return {m[7:4], m[3:0] + 4'd1};
  endfunction

  always_comb begin
    set_edge  = btn_set & ~set_hist_q;
    inc_edge  = btn_inc & ~inc_hist_q;
    en_edge   = btn_en & ~en_hist_q;
    snz_edge  = btn_snooze & ~snz_hist_q;

    tick_idle = clk_1hz_posedge && (state_q == StIdle);
    hit       = tick_idle && en_q && (cur_hour == hour_q) && (cur_min == min_q)
                && (cur_sec == 8'h00);
    chime     = CHIME_EN && tick_idle && (cur_min == 8'h00) && (cur_sec == 8'h00);

    state_d = state_q;
    if (set_edge) begin
      unique case (state_q)
        StIdle:    state_d = StSetHour;
        StSetHour: state_d = StSetMin;
        default:   state_d = StIdle;
      endcase
    end

    // A simultaneous set edge wins; the increment is dropped.
    hour_d = hour_q;
    min_d  = min_q;
    if (inc_edge && !set_edge) begin
      if (state_q == StSetHour) hour_d = inc_hour(hour_q);
      if (state_q == StSetMin)  min_d  = inc_min(min_q);
    end

    en_d     = en_q ^ en_edge;
    cnt_d    = cnt_q;
    win_d    = win_q;
    active_d = active_q;
    fire     = 1'b0;

    // Countdown and window run in every set_state; only the fire is gated to IDLE.
    if (clk_1hz_posedge) begin
      if (win_q != 4'd0) win_d = win_q - 4'd1;
      if (active_q) begin
        if (cnt_q == 10'd1) begin
          cnt_d    = 10'd0;
          active_d = 1'b0;
          win_d    = WinLoad;
          fire     = 1'b1;
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
    end

    if (snz_edge && (win_q != 4'd0)) begin
      cnt_d    = SnoozeLoad;
      active_d = 1'b1;
      win_d    = 4'd0;
    end

    if (hit) begin
      cnt_d    = 10'd0;
      active_d = 1'b0;
      win_d    = WinLoad;
    end

    if (en_edge && en_q) begin
      cnt_d    = 10'd0;
      active_d = 1'b0;
      win_d    = 4'd0;
    end

    ring1_d = hit || (fire && (state_q == StIdle));
    ring2_d = chime && !hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_hist_q <= 1'b0;
      inc_hist_q <= 1'b0;
      en_hist_q  <= 1'b0;
      snz_hist_q <= 1'b0;
      hour_q     <= 8'h07;
      min_q      <= 8'h00;
      en_q       <= 1'b0;
      active_q   <= 1'b0;
      cnt_q      <= 10'd0;
      win_q      <= 4'd0;
      ring1_q    <= 1'b0;
      ring2_q    <= 1'b0;
    end else begin
      set_hist_q <= btn_set;
      inc_hist_q <= btn_inc;
      en_hist_q  <= btn_en;
      snz_hist_q <= btn_snooze;
      hour_q     <= hour_d;
      min_q      <= min_d;
      en_q       <= en_d;
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      ring1_q    <= ring1_d;
      ring2_q    <= ring2_d;
    end
  end

  assign ring1         = ring1_q;
  assign ring2         = ring2_q;
  assign alarm_hour    = hour_q;
  assign alarm_min     = min_q;
  assign alarm_en      = en_q;
  assign set_state     = state_q;
  assign snooze_active = active_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboarded bench for alarm_trigger: each tick queues the expected ring pair,
// a negedge monitor checks it one clk later and requires quiet rings otherwise.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] cur_hour = 8'h00, cur_min = 8'h00, cur_sec = 8'h00;
  logic       btn_set = 1'b0, btn_inc = 1'b0, btn_en = 1'b0, btn_snooze = 1'b0;

  logic       ring1, ring2, alarm_en, snooze_active;
  logic [7:0] alarm_hour, alarm_min;
  logic [1:0] set_state;
  logic       nc_ring1, nc_ring2, nc_alarm_en, nc_snooze_active;
  logic [7:0] nc_alarm_hour, nc_alarm_min;
  logic [1:0] nc_set_state;

  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_q[$];
  logic       tick_prev = 1'b0;

  always #5 clk = ~clk;

  alarm_trigger #(.SNOOZE_SEC(5), .SNOOZE_WIN(3), .CHIME_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .clk_1hz_posedge(tick),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .btn_set(btn_set), .btn_inc(btn_inc), .btn_en(btn_en), .btn_snooze(btn_snooze),
    .ring1(ring1), .ring2(ring2), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_en(alarm_en), .set_state(set_state), .snooze_active(snooze_active)
  );

  alarm_trigger #(.SNOOZE_SEC(5), .SNOOZE_WIN(3), .CHIME_EN(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .clk_1hz_posedge(tick),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .btn_set(btn_set), .btn_inc(btn_inc), .btn_en(btn_en), .btn_snooze(btn_snooze),
    .ring1(nc_ring1), .ring2(nc_ring2), .alarm_hour(nc_alarm_hour),
    .alarm_min(nc_alarm_min), .alarm_en(nc_alarm_en), .set_state(nc_set_state),
    .snooze_active(nc_snooze_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) tick_prev <= tick;

  // One clk after a tick the queued ring pair must appear; otherwise rings stay low.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst) begin
      if (tick_prev) begin
        if (exp_q.size() == 0) begin
          check("ring_queue_underflow", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("ring", {30'd0, ring1, ring2}, {30'd0, e});
          check("ring_nochime", {30'd0, nc_ring1, nc_ring2}, {30'd0, e[1], 1'b0});
        end
      end else begin
        check("ring_quiet", {30'd0, ring1, ring2}, 32'd0);
        check("ring_quiet_nochime", {30'd0, nc_ring1, nc_ring2}, 32'd0);
      end
    end
  end

  // mask: [3] set, [2] inc, [1] en, [0] snooze
  task automatic press(input logic [3:0] mask, input int hold = 1);
    @(negedge clk);
    {btn_set, btn_inc, btn_en, btn_snooze} = mask;
    repeat (hold) @(negedge clk);
    {btn_set, btn_inc, btn_en, btn_snooze} = 4'b0000;
    @(negedge clk);
  endtask

  task automatic inc_n(input int n);
    repeat (n) press(4'b0100);
  endtask

  task automatic do_tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic [1:0] e);
    @(negedge clk);
    cur_hour = h;
    cur_min  = m;
    cur_sec  = s;
    tick     = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_state", {30'd0, set_state}, 32'd0);
    check("rst_hour", {24'd0, alarm_hour}, 32'h07);
    check("rst_min", {24'd0, alarm_min}, 32'h00);
    check("rst_en", {31'd0, alarm_en}, 32'd0);
    check("rst_ring", {30'd0, ring1, ring2}, 32'd0);
    rst = 1'b0;

    press(4'b1000); check("fsm_hour", {30'd0, set_state}, 32'd1);
    press(4'b1000); check("fsm_min", {30'd0, set_state}, 32'd2);
    press(4'b1000); check("fsm_idle", {30'd0, set_state}, 32'd0);
    check("fsm_hour_kept", {24'd0, alarm_hour}, 32'h07);
    inc_n(1); check("inc_idle_ignored", {24'd0, alarm_hour}, 32'h07);

    press(4'b1000);
    inc_n(3);  check("hour_09_10", {24'd0, alarm_hour}, 32'h10);
    inc_n(12); check("hour_22", {24'd0, alarm_hour}, 32'h22);
    inc_n(1);  check("hour_23", {24'd0, alarm_hour}, 32'h23);
    inc_n(1);  check("hour_wrap", {24'd0, alarm_hour}, 32'h00);
    press(4'b1000);
    inc_n(10); check("min_09_10", {24'd0, alarm_min}, 32'h10);
    inc_n(49); check("min_59", {24'd0, alarm_min}, 32'h59);
    inc_n(1);  check("min_wrap", {24'd0, alarm_min}, 32'h00);
    inc_n(30); check("min_30", {24'd0, alarm_min}, 32'h30);
    press(4'b1000); press(4'b1000);
    inc_n(6);
    press(4'b0100, 4); check("hold_single", {24'd0, alarm_hour}, 32'h07);
    press(4'b1100);
    check("set_inc_state", {30'd0, set_state}, 32'd2);
    check("set_inc_dropped", {24'd0, alarm_hour}, 32'h07);
    press(4'b1000); check("back_idle", {30'd0, set_state}, 32'd0);

    do_tick(8'h07, 8'h30, 8'h00, 2'b00);
    press(4'b0010); check("en_on", {31'd0, alarm_en}, 32'd1);
    do_tick(8'h07, 8'h30, 8'h00, 2'b10);
    do_tick(8'h07, 8'h30, 8'h01, 2'b00);
    do_tick(8'h07, 8'h30, 8'h02, 2'b00);
    press(4'b0001); check("snooze_accept", {31'd0, snooze_active}, 32'd1);
    do_tick(8'h07, 8'h30, 8'h03, 2'b00);
    do_tick(8'h07, 8'h30, 8'h04, 2'b00);
    do_tick(8'h07, 8'h30, 8'h05, 2'b00);
    do_tick(8'h07, 8'h30, 8'h06, 2'b00);
    do_tick(8'h07, 8'h30, 8'h07, 2'b10);
    check("snooze_done", {31'd0, snooze_active}, 32'd0);
    for (int i = 8; i < 12; i++) do_tick(8'h07, 8'h30, 8'(i), 2'b00);
    press(4'b0001); check("snooze_late_ignored", {31'd0, snooze_active}, 32'd0);

    // Snooze expiry while editing: countdown consumed, no ring.
    do_tick(8'h07, 8'h30, 8'h00, 2'b10);
    press(4'b0001); check("snooze_accept2", {31'd0, snooze_active}, 32'd1);
    press(4'b1000);
    for (int i = 1; i < 6; i++) do_tick(8'h07, 8'h31, 8'(i), 2'b00);
    check("snooze_consumed", {31'd0, snooze_active}, 32'd0);
    press(4'b1000); press(4'b1000);

    do_tick(8'h08, 8'h00, 8'h00, 2'b01);
    press(4'b1000); inc_n(1); press(4'b1000); inc_n(30); press(4'b1000);
    check("alarm_0800_hour", {24'd0, alarm_hour}, 32'h08);
    check("alarm_0800_min", {24'd0, alarm_min}, 32'h00);
    do_tick(8'h08, 8'h00, 8'h00, 2'b10);
    press(4'b0001); check("snooze_accept3", {31'd0, snooze_active}, 32'd1);
    do_tick(8'h08, 8'h00, 8'h00, 2'b10);
    check("hit_clears_snooze", {31'd0, snooze_active}, 32'd0);

    press(4'b0001); check("snooze_accept4", {31'd0, snooze_active}, 32'd1);
    do_tick(8'h08, 8'h00, 8'h01, 2'b00);
    do_tick(8'h08, 8'h00, 8'h02, 2'b00);
    #2 rst = 1'b1;
    #1;
    check("arst_snooze", {31'd0, snooze_active}, 32'd0);
    check("arst_en", {31'd0, alarm_en}, 32'd0);
    check("arst_hour", {24'd0, alarm_hour}, 32'h07);
    check("arst_min", {24'd0, alarm_min}, 32'h00);
    check("arst_ring", {30'd0, ring1, ring2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 3; i < 9; i++) do_tick(8'h08, 8'h00, 8'(i), 2'b00);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
